frame_write_sched: RTL

Write scheduler and port arbiter for the single-port frame RAM in the VGA serial display. It accepts 24-bit pixel words from the serial byte assembler, one `wr_valid` pulse per word, and buffers them in a small FIFO. It writes them to sequential RAM addresses only on cycles when the VGA display reader is not using the port. The display reader has absolute priority; the scheduler never stalls it.

---
 rtl/frame_write_sched.sv | 125 ++++++++++++
 1 files changed

// File: rtl/frame_write_sched.sv
// Write scheduler for the single-port frame RAM: buffers pixel words in a small
// FIFO and writes them on cycles the display reader leaves the port idle.
module frame_write_sched #(
    parameter int ADDR_W     = 10,
    parameter int MEM_DEPTH  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_valid,
    input  logic [23:0]                   wr_data,
    input  logic                          addr_clear,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [23:0]                   ram_wdata,
    output logic                          ram_we,
    output logic                          rd_grant,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic                          overflow,
    output logic                          frame_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [23:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [LVL_W-1:0]  level_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic              overflow_r;
    logic              frame_done_r;

    logic              empty_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic              last_addr_s;

    // Pop/push qualification; the reader and a clear both block the write slot.
    always_comb begin
        empty_s     = (level_r == {LVL_W{1'b0}});
        full_s      = (level_r == LVL_W'(FIFO_DEPTH));
        last_addr_s = (wr_addr_r == ADDR_W'(MEM_DEPTH - 1));
        pop_s       = !reset && !rd_req && !empty_s && !addr_clear;
        push_s      = wr_valid && !addr_clear && (!full_s || pop_s);
        drop_s      = wr_valid && !addr_clear && full_s && !pop_s;
    end

    // Zero-latency port mux: the reader always wins the RAM port.
    always_comb begin
        ram_addr  = wr_addr_r;
        ram_wdata = mem_r[head_r];
        ram_we    = 1'b0;
        rd_grant  = rd_req;
        if (rd_req) begin
            ram_addr = rd_addr;
            ram_we   = 1'b0;
        end else if (pop_s) begin
            ram_addr = wr_addr_r;
            ram_we   = 1'b1;
        end else begin
            ram_addr = wr_addr_r;
            ram_we   = 1'b0;
        end
    end

    // FIFO storage; data needs no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            mem_r[tail_r] <= wr_data;
        end
    end

    // FIFO pointers, occupancy, write address and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r       <= {PTR_W{1'b0}};
            tail_r       <= {PTR_W{1'b0}};
            level_r      <= {LVL_W{1'b0}};
            wr_addr_r    <= {ADDR_W{1'b0}};
            overflow_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else if (addr_clear) begin
            head_r       <= {PTR_W{1'b0}};
            tail_r       <= {PTR_W{1'b0}};
            level_r      <= {LVL_W{1'b0}};
            wr_addr_r    <= {ADDR_W{1'b0}};
            overflow_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
                if (last_addr_s) begin
                    wr_addr_r <= {ADDR_W{1'b0}};
                end else begin
                    wr_addr_r <= wr_addr_r + ADDR_W'(1);
                end
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            frame_done_r <= pop_s && last_addr_s;
        end
    end

    assign fifo_full  = (level_r == LVL_W'(FIFO_DEPTH));
    assign fill_level = level_r;
    assign wr_addr    = wr_addr_r;
    assign overflow   = overflow_r;
    assign frame_done = frame_done_r;

endmodule
